// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory responder.
package core_mem_pkg;

    typedef enum logic [1:0] {
        ST_BYTE = 2'b00,
        ST_HALF = 2'b01,
        ST_WORD = 2'b10,
        ST_RSVD = 2'b11
    } str_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } mem_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          NUM_LANES = 4;

endpackage

// File: rtl/core_dmem_be.sv
// Store lane decode: byte enables, lane-replicated write data and misalign flag.
module core_dmem_be
    import core_mem_pkg::*;
(
    input  logic [1:0]  str_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wr_d,
    output logic [3:0]  be,
    output logic [31:0] be_d,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        be_d     = wr_d;
        misalign = 1'b0;
        case (str_type_e'(str_type))
            ST_BYTE: begin
                be   = 4'b0001 << byte_off;
                be_d = {4{wr_d[7:0]}};
            end
            ST_HALF: begin
                be       = byte_off[1] ? 4'b1100 : 4'b0011;
                be_d     = {2{wr_d[15:0]}};
                misalign = byte_off[0];
            end
            ST_WORD: begin
                be       = 4'b1111;
                misalign = |byte_off;
            end
            default: be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/core_mem_resp.sv
// Instruction/data memory responder with program-load sequencer.
// Optional store/load alignment checking under CORE_MEM_MISALIGN_CHK_EN.
module core_mem_resp
    import core_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [8:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_done,
    input  logic [8:0]  nxt_instr,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_wr_d,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  str_type,
    output logic [31:0] instr,
    output logic [31:0] mem_rd_d,
    output logic        vld
`ifdef CORE_MEM_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int DAW = $clog2(DMEM_DEPTH);

    mem_state_e state_q, state_d;
    logic       run;
    logic       imem_we;

    logic [31:0] imem [IMEM_DEPTH];
    logic [7:0]  dmem [NUM_LANES][DMEM_DEPTH];

    logic [DAW-1:0] widx;
    logic [3:0]     be;
    logic [31:0]    be_d;
    logic           misalign;
    logic           st_we;

    // High address bits alias onto the data array.
    assign widx = alu_out[DAW+1:2];

    logic unused_addr;
    assign unused_addr = ^alu_out[31:DAW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ld_done) state_d = RUN; else if (ld_vld) state_d = LOAD;
            LOAD:    if (ld_done) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run     = (state_q == RUN);
        vld     = run;
        imem_we = ld_vld && !run;
    end

    always_ff @(posedge clk) begin
        if (imem_we) imem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      instr <= NOP_INSTR;
        else if (run) instr <= imem[nxt_instr];
        else          instr <= NOP_INSTR;
    end

    core_dmem_be u_be (
        .str_type (str_type),
        .byte_off (alu_out[1:0]),
        .wr_d     (mem_wr_d),
        .be       (be),
        .be_d     (be_d),
        .misalign (misalign)
    );

`ifdef CORE_MEM_MISALIGN_CHK_EN
    assign st_we = run && mem_wr && !misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= run && (mem_wr || mem_rd) && misalign;
    end
`else
    assign st_we = run && mem_wr;

    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (st_we && be[l]) dmem[l][widx] <= be_d[l*8 +: 8];
        end
    end

    // Combinational read returns pre-edge contents on same-word read/write.
    always_comb begin
        mem_rd_d = '0;
        if (mem_rd) begin
            for (int l = 0; l < NUM_LANES; l++) mem_rd_d[l*8 +: 8] = dmem[l][widx];
        end
    end

endmodule

// File: tb/tb_core_mem_resp.sv
// Directed self-checking bench for core_mem_resp.
module tb_core_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld, ld_done, mem_rd, mem_wr;
    logic [8:0]  ld_addr, nxt_instr;
    logic [31:0] ld_data, alu_out, mem_wr_d;
    logic [1:0]  str_type;
    logic [31:0] instr, mem_rd_d;
    logic        vld;
`ifdef CORE_MEM_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_mem_resp dut (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .nxt_instr (nxt_instr),
        .alu_out   (alu_out),
        .mem_wr_d  (mem_wr_d),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .str_type  (str_type),
        .instr     (instr),
        .mem_rd_d  (mem_rd_d),
        .vld       (vld)
`ifdef CORE_MEM_MISALIGN_CHK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        mem_wr = 1'b1; alu_out = a; mem_wr_d = d; str_type = t;
        @(posedge clk);
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ld_vld = 0; ld_done = 0; mem_rd = 0; mem_wr = 0;
        ld_addr = 0; nxt_instr = 0; ld_data = 0; alu_out = 0; mem_wr_d = 0; str_type = 2'b10;
        repeat (2) @(negedge clk);
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h13); end
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", vld); end
        n_checks++; if (mem_rd_d !== 32'h0) begin n_fail++; $display("FAIL reset_rd_d got=%h exp=0", mem_rd_d); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL idle_vld got=%b exp=0", vld); end
    endtask

    task automatic test_load;
        ld_vld = 1; ld_addr = 9'd0; ld_data = 32'h0050_0093;
        @(negedge clk);
        ld_addr = 9'd1; ld_data = 32'h00A0_0113;
        @(negedge clk);
        ld_vld = 0; ld_done = 1;
        #1;
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL load_vld_pre got=%b exp=0", vld); end
        @(posedge clk); #1;
        ld_done = 0;
        n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL load_vld_run got=%b exp=1", vld); end
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL load_instr_nop got=%h exp=00000013", instr); end
        nxt_instr = 9'd1;
        @(posedge clk); #1;
        n_checks++; if (instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL fetch1 got=%h exp=00a00113", instr); end
        nxt_instr = 9'd0;
        @(posedge clk); #1;
        n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch0 got=%h exp=00500093", instr); end
        @(negedge clk);
    endtask

    task automatic test_ld_ignored_in_run;
        ld_vld = 1; ld_addr = 9'd1; ld_data = 32'hFFFF_FFFF;
        @(negedge clk);
        ld_vld = 0; nxt_instr = 9'd1;
        @(posedge clk); #1;
        n_checks++; if (instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL ld_in_run got=%h exp=00a00113", instr); end
        @(negedge clk);
    endtask

    task automatic test_stores;
        do_store(32'h100, 32'h0, 2'b10);
        do_store(32'h102, 32'hAB, 2'b00);
        mem_rd = 1; alu_out = 32'h100; #1;
        n_checks++; if (mem_rd_d !== 32'h00AB_0000) begin n_fail++; $display("FAIL st_byte got=%h exp=00ab0000", mem_rd_d); end
        mem_rd = 0;
        do_store(32'h104, 32'h0, 2'b10);
        do_store(32'h106, 32'h1234, 2'b01);
        do_store(32'h108, 32'hDEAD_BEEF, 2'b10);
        mem_rd = 1; alu_out = 32'h104; #1;
        n_checks++; if (mem_rd_d !== 32'h1234_0000) begin n_fail++; $display("FAIL st_half got=%h exp=12340000", mem_rd_d); end
        alu_out = 32'h108; #1;
        n_checks++; if (mem_rd_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_word got=%h exp=deadbeef", mem_rd_d); end
        mem_rd = 0;
        do_store(32'h108, 32'hFFFF_FFFF, 2'b11);
        mem_rd = 1; alu_out = 32'h108; #1;
        n_checks++; if (mem_rd_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_rsvd got=%h exp=deadbeef", mem_rd_d); end
        alu_out = 32'h1108; #1;
        n_checks++; if (mem_rd_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alias got=%h exp=deadbeef", mem_rd_d); end
        mem_rd = 0; #1;
        n_checks++; if (mem_rd_d !== 32'h0) begin n_fail++; $display("FAIL rd_low got=%h exp=0", mem_rd_d); end
    endtask

    task automatic test_same_cycle_rw;
        do_store(32'h10, 32'd5, 2'b10);
        mem_rd = 1; mem_wr = 1; alu_out = 32'h10; mem_wr_d = 32'd9; str_type = 2'b10;
        #1;
        n_checks++; if (mem_rd_d !== 32'd5) begin n_fail++; $display("FAIL rw_old got=%h exp=5", mem_rd_d); end
        @(posedge clk); #1;
        mem_wr = 0;
        n_checks++; if (mem_rd_d !== 32'd9) begin n_fail++; $display("FAIL rw_new got=%h exp=9", mem_rd_d); end
        @(negedge clk);
        mem_rd = 0;
    endtask

    task automatic test_reset_mid_run;
        nxt_instr = 9'd1;
        @(posedge clk); #1;
        n_checks++; if (instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL pre_rst_instr got=%h exp=00a00113", instr); end
        @(negedge clk);
        rst = 1; #1;
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rst_async_vld got=%b exp=0", vld); end
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_async_instr got=%h exp=00000013", instr); end
        @(negedge clk);
        rst = 0;
        do_store(32'h108, 32'h77, 2'b10);
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst got=%b exp=0", vld); end
        ld_done = 1;
        @(posedge clk); #1;
        ld_done = 0;
        n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL restart_vld got=%b exp=1", vld); end
        @(posedge clk); #1;
        n_checks++; if (instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL restart_fetch got=%h exp=00a00113", instr); end
        mem_rd = 1; alu_out = 32'h108; #1;
        n_checks++; if (mem_rd_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_outside_run got=%h exp=deadbeef", mem_rd_d); end
        mem_rd = 0;
        @(negedge clk);
    endtask

`ifdef CORE_MEM_MISALIGN_CHK_EN
    task automatic test_misalign;
        do_store(32'h200, 32'h1111_1111, 2'b10);
        mem_wr = 1; alu_out = 32'h202; mem_wr_d = 32'h2222_2222; str_type = 2'b10;
        #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pre got=%b exp=0", misalign_err); end
        @(posedge clk); #1;
        mem_wr = 0;
        n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
        @(posedge clk); #1;
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
        mem_rd = 1; alu_out = 32'h200; #1;
        n_checks++; if (mem_rd_d !== 32'h1111_1111) begin n_fail++; $display("FAIL mis_suppress got=%h exp=11111111", mem_rd_d); end
        mem_rd = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_ld_ignored_in_run();
        test_stores();
        test_same_cycle_rw();
        test_reset_mid_run();
`ifdef CORE_MEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
